enigma_rotor: RTL
=================

Name: enigma_rotor

Overview:
- Single substitution rotor of the Enigma datapath. Sits directly upstream of the reflector and handles both directions:
  - Forward pass: plaintext toward the reflector.
  - Backward pass: reflector output back toward the lampboard.
- Holds a loadable 26-letter wiring table and a rotating position. It builds the inverse table itself at load time.
- Steps its position on request and emits a carry pulse to the next rotor at the notch.

Parameters:
- NOTCH, 5'd16: position index (0..25). Stepping away from this position pulses carry_out. Default is 'Q'.
- LETTERS, 26: alphabet size. Fixed; not to be overridden.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous, active-low reset
- set  input  1  synchronous load strobe; latches idx_in and pos_in
- idx_in  input  208  wiring table; entry i = idx_in[207-8i -: 8] = ASCII output for input 'A'+i (same packing as reflector idx_in)
- pos_in  input  5  initial position 0..25, latched on set
- valid  input  1  character request, single-cycle qualifier
- din  input  8  ASCII character
- dir  input  1  0 = forward (toward reflector), 1 = backward (inverse table)
- step_en  input  1  step position before encoding; honoured only when dir=0
- dout  output  8  substituted ASCII character
- done  output  1  one-cycle pulse, dout valid
- carry_out  output  1  one-cycle pulse, coincident with done, when the step left position NOTCH
- ready  output  1  table and inverse valid, accepting valid
- pos_out  output  5  current position

Behaviour:
- Reset (async, reset_n=0):
  - dout=8'h00, done=0, carry_out=0, ready=0, pos=0.
  - Forward and inverse tables cleared to 'A'.
  - State = UNCFG.
- States: UNCFG, BUILD, READY.
- Transitions on set:
  - set=1 on a clk edge in any state: latch idx_in into fwd[0..25], pos := pos_in (values >25 reduce mod 26).
  - Clear inverse table to 'A', bld_cnt := 0, go to BUILD, ready := 0.
  - set during BUILD restarts the build.
  - set outranks valid in the same cycle; that valid is dropped (no done).
- BUILD:
  - One entry per cycle: inv[fwd[bld_cnt]-'A'] := 'A'+bld_cnt.
  - bld_cnt counts 0..25; after the write at 25, go to READY with ready=1.
  - Ready rises on the 27th edge after the set edge (26 build cycles).
  - Non-permutation tables: later index wins; inverse entries that are never written stay 'A'.
  - fwd entries outside 'A'..'Z' are skipped (no inverse write).
- valid while not READY: ignored, no done, no step.
- Request in READY: valid sampled at edge N; dout, done, carry_out registered at edge N+1 (latency 1). A new valid is accepted every cycle (throughput 1/clk).
- Forward path (dir=0):
  - If step_en=1: p' = (pos==25) ? 0 : pos+1; carry_out=1 iff pos==NOTCH; pos := p'. Otherwise p' = pos.
  - c = din-'A'; s = (c+p') mod 26; t = fwd[s]-'A'; dout = ((t-p'+26) mod 26)+'A'.
  - Encoding uses the post-step position.
- Backward path (dir=1):
  - No stepping; carry_out=0.
  - s = (c+pos) mod 26; t = inv[s]-'A'; dout = ((t-pos+26) mod 26)+'A'.
- Non-letter din (outside 8'h41..8'h5A): dout=din passthrough, done=1, no step, carry_out=0.
- Arithmetic:
  - Mod-26 sums computed in 6 bits, with a single conditional subtract of 26.
  - No division or multiply by a variable.
- Outputs between pulses: done and carry_out are 0 outside their one-cycle pulses; dout holds its last value.
- Reset mid-BUILD or mid-request: immediate return to reset values; the in-flight result is lost.

Test Plan:
- Reset, then set with table "EKMFLGDQVZNTOWYHXUSPAIBRCJ" and pos_in=0 -> ready=0 for 26 cycles, ready=1 on the 27th edge; valid held during BUILD produces no done.
- pos=0, valid, din='A', dir=0, step_en=0 -> next cycle: dout='E', done=1 for one cycle, pos_out=0. Then dir=1, din='E' -> dout='A'.
- pos=0, din='A', dir=0, step_en=1 -> pos_out=1, dout='J', carry_out=0. Then dir=1, din='J' with pos=1 -> dout='A'.
- set pos_in=16 (NOTCH=16), forward step, din='A' -> carry_out=1 with done, pos_out=17. Next step -> carry_out=0. Also set pos_in=25, step -> pos_out=0, carry_out=0.
- Back-to-back valid for 4 cycles, din='A','B','C','D', step_en=1 from pos 0 -> done on 4 consecutive cycles, pos_out ends at 4.
- din=8'h20 -> dout=8'h20, no step. valid and set in the same cycle -> no done, BUILD restarts. reset_n low mid-BUILD -> ready=0, dout=0 immediately.

Source files
------------

// File: rtl/enigma_rotor.sv
// Single Enigma substitution rotor: loadable wiring table with a self-built
// inverse, a stepping position with notch carry, and a one-cycle-latency
// forward/backward character substitution.
module enigma_rotor #(
  parameter logic [4:0] NOTCH   = 5'd16,
  parameter int         LETTERS = 26
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   set,
  input  logic [8*LETTERS-1:0]   idx_in,
  input  logic [4:0]             pos_in,
  input  logic                   valid,
  input  logic [7:0]             din,
  input  logic                   dir,
  input  logic                   step_en,
  output logic [7:0]             dout,
  output logic                   done,
  output logic                   carry_out,
  output logic                   ready,
  output logic [4:0]             pos_out
);

  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_Z = 8'h5A;
  localparam logic [4:0] LAST    = 5'(LETTERS - 1);
  localparam logic [4:0] MOD5    = 5'(LETTERS);
  localparam logic [5:0] MOD6    = 6'(LETTERS);

  typedef enum logic [1:0] {UNCFG, BUILD, READY} state_t;

  state_t     state;
  logic [7:0] fwd [LETTERS];
  logic [7:0] inv [LETTERS];
  logic [4:0] bld_cnt;
  logic [4:0] pos;

  logic [4:0] pos_next;
  logic [4:0] pos_use;
  logic [4:0] pos_load;
  logic [4:0] c_idx;
  logic [4:0] s_idx;
  logic [4:0] t_idx;
  logic [4:0] o_idx;
  logic [7:0] table_out;
  logic [7:0] enc_out;
  logic       do_step;

  // Sum of two residues reduced mod 26 with a single conditional subtract;
  // 6 bits hold the worst case 31 + 26.
  function automatic logic [4:0] mod_add(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= MOD6) sum = sum - MOD6;
    return sum[4:0];
  endfunction

  function automatic logic is_letter(input logic [7:0] ch);
    return (ch >= ASCII_A) && (ch <= ASCII_Z);
  endfunction

  // Letter to 0..25; anything else maps to 0 (callers gate on is_letter).
  function automatic logic [4:0] to_index(input logic [7:0] ch);
    logic [7:0] d;
    d = ch - ASCII_A;
    return (d < 8'(LETTERS)) ? d[4:0] : 5'd0;
  endfunction

  assign pos_out = pos;

  // Position arithmetic and the substitution path shared by both directions
  always_comb begin
    pos_next  = (pos == LAST) ? 5'd0 : pos + 5'd1;
    pos_load  = (pos_in >= MOD5) ? pos_in - MOD5 : pos_in;
    do_step   = !dir && step_en;
    pos_use   = do_step ? pos_next : pos;
    c_idx     = to_index(din);
    s_idx     = mod_add(c_idx, pos_use);
    table_out = dir ? inv[s_idx] : fwd[s_idx];
    t_idx     = to_index(table_out);
    // Subtracting p is adding (26 - p); p = 0 gives 26, which the reduce absorbs.
    o_idx     = mod_add(t_idx, MOD5 - pos_use);
    enc_out   = ASCII_A + {3'b000, o_idx};
  end

  // Wiring table load on set; inverse filled one entry per BUILD cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LETTERS; i++) begin
        fwd[i] <= ASCII_A;
        inv[i] <= ASCII_A;
      end
    end else if (set) begin
      for (int i = 0; i < LETTERS; i++) begin
        fwd[i] <= idx_in[8*LETTERS-1-8*i -: 8];
        inv[i] <= ASCII_A;
      end
    end else if (state == BUILD && is_letter(fwd[bld_cnt])) begin
      inv[to_index(fwd[bld_cnt])] <= ASCII_A + {3'b000, bld_cnt};
    end
  end

  // Configuration FSM, stepping position and registered request outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= UNCFG;
      bld_cnt   <= 5'd0;
      pos       <= 5'd0;
      ready     <= 1'b0;
      done      <= 1'b0;
      carry_out <= 1'b0;
      dout      <= 8'h00;
    end else begin
      done      <= 1'b0;
      carry_out <= 1'b0;
      if (set) begin
        pos     <= pos_load;
        bld_cnt <= 5'd0;
        ready   <= 1'b0;
        state   <= BUILD;
      end else begin
        case (state)
          UNCFG: ;
          BUILD: begin
            if (bld_cnt == LAST) begin
              state <= READY;
              ready <= 1'b1;
            end else begin
              bld_cnt <= bld_cnt + 5'd1;
            end
          end
          READY: begin
            if (valid) begin
              done <= 1'b1;
              if (!is_letter(din)) begin
                dout <= din;
              end else begin
                dout <= enc_out;
                if (do_step) begin
                  pos       <= pos_next;
                  carry_out <= (pos == NOTCH);
                end
              end
            end
          end
          default: state <= UNCFG;
        endcase
      end
    end
  end

endmodule
